pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum MEM_WAIT cycles before forced release.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 each: ID-stage source register numbers.
REQ-006 SHALL have ports id_uses_rs1 and id_uses_rs2, input, 1 each: ID instruction reads that source.
REQ-007 SHALL have ports ex_rd (input, 5), ex_memread (input, 1) and ex_regwrite (input, 1): EX-stage destination and load/write flags.
REQ-008 SHALL have port branch_taken, input, 1: EX-stage redirect, held stable while the pipeline is frozen.
REQ-009 SHALL have ports mem_req and mem_ready, input, 1 each: MEM-stage multi-cycle access request and completion.
REQ-010 SHALL have ports io_req and io_done, input, 1 each: blocking IO (ecall) request and completion.
REQ-011 SHALL have outputs pc_en, ifid_en, idex_en and exmem_en, 1 each: stage-register enables.
REQ-012 SHALL have outputs ifid_flush and idex_flush, 1 each: load a bubble (all-zero control) into the register.
REQ-013 SHALL have output timeout_err, 1: one-cycle pulse on MEM_WAIT timeout.
REQ-014 SHALL have output stall_cnt, CNT_W bits: saturating count of stalled cycles.
REQ-015 SHALL have output state_o, 2 bits: current FSM state.

Function
REQ-016 SHALL implement FSM states INIT=0, RUN=1, MEM_WAIT=2, IO_WAIT=3, registered; all outputs except stall_cnt and timeout_err SHALL be combinational from state and inputs.
REQ-017 SHALL, in INIT, drive all enables 0 and both flushes 1, then go to RUN on the first clk edge after reset release.
REQ-018 SHALL, in RUN with no event, drive all enables 1 and both flushes 0.
REQ-019 SHALL define load_use = ex_memread & ex_regwrite & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
REQ-020 SHALL, in RUN on load_use & !branch_taken, drive pc_en=0, ifid_en=0 and idex_flush=1, and stay in RUN; this is a single-cycle bubble.
REQ-021 SHALL, in RUN on branch_taken, drive ifid_flush=1 and idex_flush=1 with pc_en=1; branch_taken SHALL override load_use.
REQ-022 SHALL, in RUN on mem_req & !mem_ready, drive all enables 0 and flushes 0, and go to MEM_WAIT.
REQ-023 SHALL treat mem_req & mem_ready in the same cycle as zero-wait: no freeze, stay in RUN.
REQ-024 SHALL give mem_req priority over io_req and over branch_taken/load_use; suppressed events SHALL be re-evaluated on release because the frozen stages hold them stable.
REQ-025 SHALL, in RUN on io_req (no mem_req), freeze all enables and go to IO_WAIT.
REQ-026 SHALL, in MEM_WAIT, keep all enables 0 until mem_ready; on the mem_ready cycle it SHALL apply RUN outputs and go to RUN.
REQ-027 SHALL count MEM_WAIT cycles in an internal counter; when it reaches TIMEOUT without mem_ready, it SHALL pulse timeout_err for one cycle, apply RUN outputs and go to RUN.
REQ-028 SHALL clear the wait counter on entry to MEM_WAIT.
REQ-029 SHALL, in IO_WAIT, freeze until io_done, then apply RUN outputs and go to RUN; there is no timeout in IO_WAIT.
REQ-030 SHALL increment stall_cnt on every clk edge where pc_en=0 and state != INIT, saturating at all-ones.

Reset
REQ-031 SHALL, while rst_n=1, force state=INIT, stall_cnt=0, wait counter=0 and timeout_err=0; outputs SHALL then be pc_en=0, ifid_en=0, idex_en=0, exmem_en=0, ifid_flush=1, idex_flush=1.
REQ-032 SHALL, on reset asserted mid-MEM_WAIT or mid-IO_WAIT, abandon the wait immediately with no pending event retained.

Structure
REQ-033 SHALL place the state encodings and the default TIMEOUT in the shared CPU package.
REQ-034 SHALL implement the load_use comparator as sub-module hazard_detect; there SHALL be no other sub-modules.

Verification
REQ-035 SHALL cover: release reset -> INIT for 1 cycle with both flushes 1, then RUN with all enables 1.
REQ-036 SHALL cover: ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle pc_en=0, idex_flush=1, stall_cnt +1; the same with ex_rd=0 -> no stall.
REQ-037 SHALL cover: load_use and branch_taken together -> ifid_flush=1, idex_flush=1, pc_en=1, stall_cnt unchanged.
REQ-038 SHALL cover: mem_req held, mem_ready after 4 cycles -> MEM_WAIT for 4 cycles, stall_cnt=5, enables 1 on the ready cycle.
REQ-039 SHALL cover: TIMEOUT=8, mem_ready never -> timeout_err pulses on the 8th MEM_WAIT cycle, then RUN.
REQ-040 SHALL cover: mem_req and io_req together -> MEM_WAIT first; after mem_ready -> IO_WAIT; io_done -> RUN; reset asserted in IO_WAIT -> INIT immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU pipeline definitions: hazard-controller state encodings, defaults
// and the stage-control bundle the controller drives each cycle.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_IO_WAIT  = 2'd3
   } state_e;

   localparam int TIMEOUT_DEFAULT = 255;
   localparam int CNT_W_DEFAULT   = 16;
   localparam int REG_W           = 5;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic ifid_flush;
      logic idex_flush;
   } ctrl_t;

   // Bit order follows ctrl_t: {pc, ifid, idex, exmem, ifid_flush, idex_flush}.
   localparam ctrl_t CTRL_INIT   = ctrl_t'(6'b0000_11);
   localparam ctrl_t CTRL_RUN    = ctrl_t'(6'b1111_00);
   localparam ctrl_t CTRL_FREEZE = ctrl_t'(6'b0000_00);
   localparam ctrl_t CTRL_BUBBLE = ctrl_t'(6'b0011_01);
   localparam ctrl_t CTRL_BRANCH = ctrl_t'(6'b1111_11);

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID-stage read of a register that the load
// currently in EX has not produced yet. x0 never creates a dependency.
module hazard_detect
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   output logic             load_use
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
   assign load_use = ex_memread && ex_regwrite && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, and freezes
// for multi-cycle memory accesses (with timeout) and blocking IO.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             io_req,
   input  logic             io_done,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       state_o
);

   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

   state_e            state;
   state_e            state_next;
   ctrl_t             ctrl;
   logic              load_use;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_next;
   logic              timeout_next;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_rd       (ex_rd),
      .ex_memread  (ex_memread),
      .ex_regwrite (ex_regwrite),
      .load_use    (load_use)
   );

   // A memory stall outranks everything; frozen stages keep the other
   // requests stable, so they are simply seen again once RUN resumes.
   always_comb begin
      state_next = state;
      ctrl       = CTRL_RUN;
      unique case (state)
         ST_INIT: begin
            ctrl       = CTRL_INIT;
            state_next = ST_RUN;
         end
         ST_RUN: begin
            if (mem_req && !mem_ready) begin
               ctrl       = CTRL_FREEZE;
               state_next = ST_MEM_WAIT;
            end else if (io_req) begin
               ctrl       = CTRL_FREEZE;
               state_next = ST_IO_WAIT;
            end else if (branch_taken) begin
               ctrl = CTRL_BRANCH;
            end else if (load_use) begin
               ctrl = CTRL_BUBBLE;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready || timeout_err) begin
               state_next = ST_RUN;
            end else begin
               ctrl = CTRL_FREEZE;
            end
         end
         ST_IO_WAIT: begin
            if (io_done) begin
               state_next = ST_RUN;
            end else begin
               ctrl = CTRL_FREEZE;
            end
         end
         default: begin
            ctrl       = CTRL_INIT;
            state_next = ST_INIT;
         end
      endcase
   end

   // wait_cnt holds the number of MEM_WAIT cycles already completed. The
   // timeout flag is registered one edge early so it is high during the
   // TIMEOUT-th wait cycle, which is also the cycle that releases the freeze.
   always_comb begin
      wait_cnt_next = (state == ST_MEM_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      timeout_next  = (state_next == ST_MEM_WAIT) && (wait_cnt_next == LAST_WAIT);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state       <= ST_INIT;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
         stall_cnt   <= '0;
      end else begin
         state       <= state_next;
         wait_cnt    <= wait_cnt_next;
         timeout_err <= timeout_next;
         if (!ctrl.pc_en && (state != ST_INIT) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   assign pc_en      = ctrl.pc_en;
   assign ifid_en    = ctrl.ifid_en;
   assign idex_en    = ctrl.idex_en;
   assign exmem_en   = ctrl.exmem_en;
   assign ifid_flush = ctrl.ifid_flush;
   assign idex_flush = ctrl.idex_flush;
   assign state_o    = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a driver issues one input vector per
// cycle and queues the expected outputs; a monitor checks them mid-cycle.
module tb_pipe_hazard_ctrl;

   localparam int EXP_W = 25;
   localparam logic [5:0] O_INIT = 6'b0000_11;
   localparam logic [5:0] O_RUN  = 6'b1111_00;
   localparam logic [5:0] O_FRZ  = 6'b0000_00;
   localparam logic [5:0] O_LU   = 6'b0011_01;
   localparam logic [5:0] O_BR   = 6'b1111_11;
   localparam logic [1:0] S_INIT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_MW   = 2'd2;
   localparam logic [1:0] S_IO   = 2'd3;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs1, id_uses_rs2, ex_memread, ex_regwrite;
   logic branch_taken, mem_req, mem_ready, io_req, io_done;

   logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, timeout_err;
   logic [15:0] stall_cnt;
   logic [1:0] state_o;

   logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_ifid_flush, s_idex_flush, s_timeout_err;
   logic [1:0] s_stall_cnt;
   logic [1:0] s_state_o;

   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .io_req(io_req), .io_done(io_done),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .timeout_err(timeout_err),
      .stall_cnt(stall_cnt), .state_o(state_o)
   );

   // Narrow counter copy to observe saturation at all-ones.
   pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .io_req(io_req), .io_done(io_done),
      .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
      .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .timeout_err(s_timeout_err),
      .stall_cnt(s_stall_cnt), .state_o(s_state_o)
   );

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = '0; ex_memread = 1'b0; ex_regwrite = 1'b0;
      branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      io_req = 1'b0; io_done = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
      idle();
   endtask

   task automatic ld(input logic [4:0] rd, input logic mr, input logic rw,
                     input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2);
      ex_rd = rd; ex_memread = mr; ex_regwrite = rw;
      id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
   endtask

   task automatic expect_out(input logic [1:0] st, input logic [5:0] o,
                             input logic te, input int cnt);
      exp_q.push_back({st, o, te, 16'(cnt)});
   endtask

   always @(negedge clk) begin : monitor
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] act;
      logic [10:0] s_exp;
      logic [10:0] s_act;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         act = {state_o, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
                timeout_err, stall_cnt};
         n_checks++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL main cyc %0d: got st=%0d ctl=%b terr=%b cnt=%0d, want st=%0d ctl=%b terr=%b cnt=%0d",
                     cyc, act[24:23], act[22:17], act[16], act[15:0],
                     e[24:23], e[22:17], e[16], e[15:0]);
         end
         s_exp = {e[24:16], (e[15:0] > 16'd3) ? 2'd3 : e[1:0]};
         s_act = {s_state_o, s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_ifid_flush,
                  s_idex_flush, s_timeout_err, s_stall_cnt};
         n_checks++;
         if (s_act !== s_exp) begin
            n_fail++;
            $display("FAIL sat cyc %0d: got %b want %b", cyc, s_act, s_exp);
         end
      end
   end

   initial begin
      rst_n = 1'b1;
      idle();
      // reset, then one INIT cycle after release
      tick(); expect_out(S_INIT, O_INIT, 0, 0);
      tick(); expect_out(S_INIT, O_INIT, 0, 0);
      tick(); rst_n = 1'b0; expect_out(S_INIT, O_INIT, 0, 0);
      tick(); expect_out(S_RUN, O_RUN, 0, 0);
      // load-use variants
      tick(); ld(5, 1, 1, 3, 1, 5, 1); expect_out(S_RUN, O_LU, 0, 0);
      tick(); expect_out(S_RUN, O_RUN, 0, 1);
      tick(); ld(0, 1, 1, 3, 1, 0, 1); expect_out(S_RUN, O_RUN, 0, 1);
      tick(); ld(7, 1, 1, 7, 1, 2, 0); expect_out(S_RUN, O_LU, 0, 1);
      tick(); ld(7, 1, 1, 7, 0, 7, 0); expect_out(S_RUN, O_RUN, 0, 2);
      tick(); ld(7, 0, 1, 7, 1, 7, 1); expect_out(S_RUN, O_RUN, 0, 2);
      tick(); ld(5, 1, 1, 3, 1, 5, 1); branch_taken = 1'b1; expect_out(S_RUN, O_BR, 0, 2);
      tick(); expect_out(S_RUN, O_RUN, 0, 2);
      // zero-wait memory access
      tick(); mem_req = 1'b1; mem_ready = 1'b1; expect_out(S_RUN, O_RUN, 0, 2);
      tick(); expect_out(S_RUN, O_RUN, 0, 2);
      // memory wait: 4 frozen MEM_WAIT cycles, then ready
      tick(); mem_req = 1'b1; expect_out(S_RUN, O_FRZ, 0, 2);
      for (int k = 0; k < 4; k++) begin
         tick(); mem_req = 1'b1; expect_out(S_MW, O_FRZ, 0, 3 + k);
      end
      tick(); mem_req = 1'b1; mem_ready = 1'b1; expect_out(S_MW, O_RUN, 0, 7);
      tick(); expect_out(S_RUN, O_RUN, 0, 7);
      // timeout on the 8th MEM_WAIT cycle
      tick(); mem_req = 1'b1; expect_out(S_RUN, O_FRZ, 0, 7);
      for (int k = 0; k < 7; k++) begin
         tick(); mem_req = 1'b1; expect_out(S_MW, O_FRZ, 0, 8 + k);
      end
      tick(); mem_req = 1'b1; expect_out(S_MW, O_RUN, 1, 15);
      tick(); expect_out(S_RUN, O_RUN, 0, 15);
      // mem_req and io_req together: memory first, then IO
      tick(); mem_req = 1'b1; io_req = 1'b1; expect_out(S_RUN, O_FRZ, 0, 15);
      tick(); mem_req = 1'b1; io_req = 1'b1; expect_out(S_MW, O_FRZ, 0, 16);
      tick(); mem_req = 1'b1; io_req = 1'b1; mem_ready = 1'b1; expect_out(S_MW, O_RUN, 0, 17);
      tick(); io_req = 1'b1; expect_out(S_RUN, O_FRZ, 0, 17);
      for (int k = 0; k < 10; k++) begin
         tick(); io_req = 1'b1; expect_out(S_IO, O_FRZ, 0, 18 + k);
      end
      tick(); io_req = 1'b1; io_done = 1'b1; expect_out(S_IO, O_RUN, 0, 28);
      tick(); expect_out(S_RUN, O_RUN, 0, 28);
      // reset asserted inside IO_WAIT
      tick(); io_req = 1'b1; expect_out(S_RUN, O_FRZ, 0, 28);
      tick(); io_req = 1'b1; expect_out(S_IO, O_FRZ, 0, 29);
      tick(); io_req = 1'b1; rst_n = 1'b1; expect_out(S_INIT, O_INIT, 0, 0);
      tick(); io_req = 1'b1; expect_out(S_INIT, O_INIT, 0, 0);
      tick(); rst_n = 1'b0; expect_out(S_INIT, O_INIT, 0, 0);
      tick(); expect_out(S_RUN, O_RUN, 0, 0);
      // reset asserted inside MEM_WAIT
      tick(); mem_req = 1'b1; expect_out(S_RUN, O_FRZ, 0, 0);
      tick(); mem_req = 1'b1; expect_out(S_MW, O_FRZ, 0, 1);
      tick(); mem_req = 1'b1; rst_n = 1'b1; expect_out(S_INIT, O_INIT, 0, 0);
      tick(); rst_n = 1'b0; expect_out(S_INIT, O_INIT, 0, 0);
      tick(); expect_out(S_RUN, O_RUN, 0, 0);
      tick(); expect_out(S_RUN, O_RUN, 0, 0);
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
